// File: rtl/wakeup_broadcaster_pkg.sv
// Shared types for the wakeup broadcaster: tag width, channel FSM states,
// the broadcast record and a small popcount helper for the 2-wide FIFO.
package wakeup_broadcaster_pkg;

  localparam int WAKEUP_TAG_W = 7;

  typedef enum logic {
    WK_IDLE = 1'b0,
    WK_HOLD = 1'b1
  } wakeup_ch_state_t;

  typedef struct packed {
    logic                    valid;
    logic [WAKEUP_TAG_W-1:0] tag;
  } wakeup_bcast_t;

  // Number of set bits in a 2-bit request vector (0..2).
  function automatic logic [1:0] wk_cnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/wakeup_broadcaster_if.sv
// Bundles the ALU completion inputs, the two wakeup channels to the
// reservation station, the PRF ready-set strobes and debug occupancy.
// master = the broadcaster, slave = its surroundings.
interface wakeup_broadcaster_if
  import wakeup_broadcaster_pkg::*;
#(
  parameter int TAG_W = WAKEUP_TAG_W,
  parameter int CNT_W = 3
);
  logic [1:0]            fu_done_valid;
  logic [1:0][TAG_W-1:0] fu_prd;
  logic [1:0]            fu_done_ready;
  logic                  flush;
  logic [TAG_W-1:0]      reg1_rdy;
  logic                  reg1_rdy_valid;
  logic                  set_reg1_rdy;
  logic [TAG_W-1:0]      reg2_rdy;
  logic                  reg2_rdy_valid;
  logic                  set_reg2_rdy;
  logic [1:0]            prf_set_valid;
  logic [1:0][TAG_W-1:0] prf_set_tag;
  logic [CNT_W-1:0]      count;

  modport master (
    input  fu_done_valid, fu_prd, flush, set_reg1_rdy, set_reg2_rdy,
    output fu_done_ready, reg1_rdy, reg1_rdy_valid, reg2_rdy, reg2_rdy_valid,
           prf_set_valid, prf_set_tag, count
  );

  modport slave (
    output fu_done_valid, fu_prd, flush, set_reg1_rdy, set_reg2_rdy,
    input  fu_done_ready, reg1_rdy, reg1_rdy_valid, reg2_rdy, reg2_rdy_valid,
           prf_set_valid, prf_set_tag, count
  );
endinterface

// File: rtl/wakeup_tag_fifo.sv
// 2-write / 2-read circular FIFO of completed destination tags.
// i_push[0] is written before i_push[1]; i_pop is thermometer coded
// (01 = one pop, 11 = two pops). o_head exposes the two oldest entries.
module wakeup_tag_fifo
  import wakeup_broadcaster_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = WAKEUP_TAG_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic [1:0]            i_push,
  input  logic [1:0][TAG_W-1:0] i_wdata,
  input  logic [1:0]            i_pop,
  output logic [CW-1:0]         o_count,
  output logic [1:0][TAG_W-1:0] o_head
);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       w_npush;
  logic [1:0]       w_npop;
  logic [PW-1:0]    w_wptr1;
  logic [PW-1:0]    w_rptr1;

  assign w_npush = wk_cnt2(i_push);
  assign w_npop  = wk_cnt2(i_pop);
  // The second write lands one slot further only if the first one happened.
  assign w_wptr1 = r_wptr + PW'(i_push[0]);
  assign w_rptr1 = r_rptr + PW'(1);

  // Tag storage; occupancy is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_push[0]) r_mem[r_wptr]  <= i_wdata[0];
    if (i_push[1]) r_mem[w_wptr1] <= i_wdata[1];
  end

  // Pointers and occupancy, wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_npush);
      r_rptr  <= r_rptr + PW'(w_npop);
      r_count <= r_count + CW'(w_npush) - CW'(w_npop);
    end
  end

  assign o_count   = r_count;
  assign o_head[0] = r_mem[r_rptr];
  assign o_head[1] = r_mem[w_rptr1];

endmodule

// File: rtl/wakeup_broadcaster.sv
// Collects ALU completion tags into a small FIFO and broadcasts them on two
// wakeup channels. Each channel holds its tag until acknowledged or until
// HOLD_MAX cycles pass, then pulses the PRF ready-set strobe for one cycle.
module wakeup_broadcaster
  import wakeup_broadcaster_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_MAX = 3,
  parameter int TAG_W    = WAKEUP_TAG_W
) (
  input logic                 clk,
  input logic                 reset,
  wakeup_broadcaster_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0]            w_count;
  logic [CW-1:0]            w_space;
  logic [1:0][TAG_W-1:0]    w_head;
  logic [1:0]               w_ready;
  logic [1:0]               w_push;
  logic [1:0]               w_pop;
  logic [1:0]               w_ack;
  logic [1:0]               w_retire;
  logic [1:0]               w_free;
  logic [1:0]               w_load;
  logic [1:0][TAG_W-1:0]    w_load_tag;

  wakeup_ch_state_t         r_state    [2];
  wakeup_ch_state_t         w_state_nx [2];
  logic [1:0][HW-1:0]       r_hold;
  logic [1:0][HW-1:0]       w_hold_nx;
  logic [1:0][TAG_W-1:0]    r_tag;
  logic [1:0][TAG_W-1:0]    w_tag_nx;
  logic [1:0]               r_prf_valid;
  logic [1:0][TAG_W-1:0]    r_prf_tag;

  // Readiness looks only at the registered occupancy; same-cycle pops are
  // deliberately not credited.
  assign w_space    = CW'(DEPTH) - w_count;
  assign w_ready[0] = (w_space >= CW'(1));
  assign w_ready[1] = (w_space >= CW'(2));

  // Tag 0 is accepted but never stored; flush discards everything.
  assign w_push[0] = bus.fu_done_valid[0] & w_ready[0] & (bus.fu_prd[0] != '0) & ~bus.flush;
  assign w_push[1] = bus.fu_done_valid[1] & w_ready[1] & (bus.fu_prd[1] != '0) & ~bus.flush;

  assign w_ack = {bus.set_reg2_rdy, bus.set_reg1_rdy};
  assign w_pop = {w_load[0] & w_load[1], w_load[0] | w_load[1]};

  wakeup_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_wdata (bus.fu_prd),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Channel next-state: retire decision, FIFO pop arbitration, reload.
  always_comb begin
    w_retire   = '0;
    w_free     = '0;
    w_load     = '0;
    w_load_tag = '0;
    w_hold_nx  = r_hold;
    w_tag_nx   = r_tag;
    for (int c = 0; c < 2; c++) begin
      w_state_nx[c] = r_state[c];
      w_retire[c]   = (r_state[c] == WK_HOLD) && (w_ack[c] || (r_hold[c] == HW'(HOLD_MAX)));
      w_free[c]     = (r_state[c] == WK_IDLE) || w_retire[c];
    end
    // Channel 1 gets the head; channel 2 the next entry, or the head if
    // channel 1 is still busy.
    if (!bus.flush) begin
      if (w_free[0] && (w_count != '0)) begin
        w_load[0]     = 1'b1;
        w_load_tag[0] = w_head[0];
      end
      if (w_free[1]) begin
        if (w_load[0] && (w_count >= CW'(2))) begin
          w_load[1]     = 1'b1;
          w_load_tag[1] = w_head[1];
        end else if (!w_load[0] && (w_count != '0)) begin
          w_load[1]     = 1'b1;
          w_load_tag[1] = w_head[0];
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (bus.flush) begin
        w_state_nx[c] = WK_IDLE;
        w_hold_nx[c]  = '0;
        w_tag_nx[c]   = '0;
      end else if (w_load[c]) begin
        w_state_nx[c] = WK_HOLD;
        w_hold_nx[c]  = HW'(1);
        w_tag_nx[c]   = w_load_tag[c];
      end else if (w_retire[c]) begin
        w_state_nx[c] = WK_IDLE;
        w_hold_nx[c]  = '0;
        w_tag_nx[c]   = '0;
      end else if (r_state[c] == WK_HOLD) begin
        w_hold_nx[c]  = r_hold[c] + HW'(1);
      end
    end
  end

  // Channel state, hold counters and the tags being driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) r_state[c] <= WK_IDLE;
      r_hold <= '0;
      r_tag  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) r_state[c] <= w_state_nx[c];
      r_hold <= w_hold_nx;
      r_tag  <= w_tag_nx;
    end
  end

  // One-cycle PRF ready-set strobe for every tag a channel retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prf_valid <= '0;
      r_prf_tag   <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_prf_valid[c] <= w_retire[c] & ~bus.flush;
        r_prf_tag[c]   <= (w_retire[c] && !bus.flush) ? r_tag[c] : '0;
      end
    end
  end

  assign bus.fu_done_ready  = w_ready;
  assign bus.reg1_rdy       = r_tag[0];
  assign bus.reg1_rdy_valid = (r_state[0] == WK_HOLD);
  assign bus.reg2_rdy       = r_tag[1];
  assign bus.reg2_rdy_valid = (r_state[1] == WK_HOLD);
  assign bus.prf_set_valid  = r_prf_valid;
  assign bus.prf_set_tag    = r_prf_tag;
  assign bus.count          = w_count;

endmodule

// File: tb/tb_wakeup_broadcaster.sv
// Bench for wakeup_broadcaster: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_wakeup_broadcaster;
  import wakeup_broadcaster_pkg::*;

  localparam int DEPTH    = 4;
  localparam int HOLD_MAX = 3;
  localparam int TAG_W    = 7;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wakeup_broadcaster_if #(.TAG_W(TAG_W), .CNT_W(CW)) bus ();

  wakeup_broadcaster #(
    .DEPTH    (DEPTH),
    .HOLD_MAX (HOLD_MAX),
    .TAG_W    (TAG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as a queue, channels as broadcast records.
  logic [TAG_W-1:0] m_q [$];
  wakeup_bcast_t    m_ch [2];
  int               m_age [2];
  logic [1:0]       m_prf_v;
  logic [TAG_W-1:0] m_prf_tag [2];

  logic             logging = 1'b0;
  logic [TAG_W-1:0] ret_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    for (int c = 0; c < 2; c++) begin
      m_ch[c]      = '0;
      m_age[c]     = 0;
      m_prf_tag[c] = '0;
    end
    m_prf_v = '0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs as driven.
  function automatic void model_step();
    logic [1:0]       rdy;
    logic [1:0]       ack;
    logic [1:0]       ret;
    logic [TAG_W-1:0] prd [2];
    if (bus.flush) begin
      model_reset();
      return;
    end
    ack    = {bus.set_reg2_rdy, bus.set_reg1_rdy};
    prd[0] = bus.fu_prd[0];
    prd[1] = bus.fu_prd[1];
    rdy[0] = (DEPTH - int'(m_q.size())) >= 1;
    rdy[1] = (DEPTH - int'(m_q.size())) >= 2;
    for (int c = 0; c < 2; c++) begin
      ret[c]       = m_ch[c].valid && (ack[c] || m_age[c] == HOLD_MAX);
      m_prf_v[c]   = ret[c];
      m_prf_tag[c] = ret[c] ? m_ch[c].tag : '0;
    end
    // Channels draw from the queue in priority order before new tags arrive.
    for (int c = 0; c < 2; c++) begin
      if (!m_ch[c].valid || ret[c]) begin
        if (m_q.size() > 0) begin
          m_ch[c].tag   = m_q.pop_front();
          m_ch[c].valid = 1'b1;
          m_age[c]      = 1;
        end else begin
          m_ch[c]  = '0;
          m_age[c] = 0;
        end
      end else begin
        m_age[c]++;
      end
    end
    for (int i = 0; i < 2; i++)
      if (bus.fu_done_valid[i] && rdy[i] && prd[i] != '0) m_q.push_back(prd[i]);
  endfunction

  task automatic compare_all();
    int sz;
    sz = m_q.size();
    check("reg1_rdy",       bus.reg1_rdy,         m_ch[0].tag);
    check("reg1_rdy_valid", bus.reg1_rdy_valid,   m_ch[0].valid);
    check("reg2_rdy",       bus.reg2_rdy,         m_ch[1].tag);
    check("reg2_rdy_valid", bus.reg2_rdy_valid,   m_ch[1].valid);
    check("prf_set_valid",  bus.prf_set_valid,    m_prf_v);
    check("prf_set_tag0",   bus.prf_set_tag[0],   m_prf_tag[0]);
    check("prf_set_tag1",   bus.prf_set_tag[1],   m_prf_tag[1]);
    check("count",          bus.count,            sz);
    check("fu_done_ready",  bus.fu_done_ready,    {DEPTH - sz >= 2, DEPTH - sz >= 1});
    if (logging) begin
      if (bus.prf_set_valid[0]) ret_log.push_back(bus.prf_set_tag[0]);
      if (bus.prf_set_valid[1]) ret_log.push_back(bus.prf_set_tag[1]);
    end
  endtask

  task automatic drive(input logic [1:0] fv, input logic [TAG_W-1:0] p0,
                       input logic [TAG_W-1:0] p1, input logic fl, input logic [1:0] ak);
    bus.fu_done_valid = fv;
    bus.fu_prd        = {p1, p0};
    bus.flush         = fl;
    bus.set_reg1_rdy  = ak[0];
    bus.set_reg2_rdy  = ak[1];
  endtask

  // Drive at the falling edge, step the model at the rising edge, compare
  // at the next falling edge.
  task automatic cyc(input logic [1:0] fv, input logic [TAG_W-1:0] p0,
                     input logic [TAG_W-1:0] p1, input logic fl, input logic [1:0] ak);
    drive(fv, p0, p1, fl, ak);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, '0, '0, 1'b0, 2'b11);
  endtask

  initial begin
    int bias;
    drive(2'b00, '0, '0, 1'b0, 2'b00);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_reg1_valid", bus.reg1_rdy_valid, 0);
    check("rst_reg2_valid", bus.reg2_rdy_valid, 0);
    check("rst_reg1_rdy",   bus.reg1_rdy,       0);
    check("rst_reg2_rdy",   bus.reg2_rdy,       0);
    check("rst_prf_valid",  bus.prf_set_valid,  0);
    check("rst_prf_tag",    bus.prf_set_tag,    0);
    check("rst_count",      bus.count,          0);
    check("rst_ready",      bus.fu_done_ready,  2'b11);
    model_reset();
    reset = 1'b1;

    // Single tag with acknowledge held high.
    cyc(2'b01, 7'd12, '0, 1'b0, 2'b11);
    check("single_cnt", bus.count, 1);
    cyc(2'b00, '0, '0, 1'b0, 2'b11);
    check("single_vld", bus.reg1_rdy_valid, 1);
    check("single_tag", bus.reg1_rdy, 12);
    cyc(2'b00, '0, '0, 1'b0, 2'b11);
    check("single_prf",     bus.prf_set_valid, 2'b01);
    check("single_prf_tag", bus.prf_set_tag[0], 12);
    check("single_release", bus.reg1_rdy_valid, 0);
    drain(2);

    // Dual push, no acknowledge: both held HOLD_MAX cycles then retired.
    cyc(2'b11, 7'd5, 7'd9, 1'b0, 2'b00);
    for (int k = 0; k < HOLD_MAX; k++) begin
      cyc(2'b00, '0, '0, 1'b0, 2'b00);
      check("dual_hold", {bus.reg2_rdy_valid, bus.reg1_rdy_valid}, 2'b11);
    end
    cyc(2'b00, '0, '0, 1'b0, 2'b00);
    check("dual_prf",  bus.prf_set_valid, 2'b11);
    check("dual_tags", bus.prf_set_tag, {7'd9, 7'd5});
    check("dual_idle", {bus.reg2_rdy_valid, bus.reg1_rdy_valid}, 2'b00);
    drain(2);

    // Back-to-back stream with acknowledge always high.
    logging = 1'b1;
    ret_log.delete();
    cyc(2'b11, 7'd1, 7'd2, 1'b0, 2'b11);
    cyc(2'b11, 7'd3, 7'd4, 1'b0, 2'b11);
    cyc(2'b11, 7'd5, 7'd6, 1'b0, 2'b11);
    drain(6);
    logging = 1'b0;
    check("b2b_n", ret_log.size(), 6);
    for (int i = 0; i < 6 && i < ret_log.size(); i++) check("b2b_order", ret_log[i], i + 1);

    // Fill the FIFO with no acknowledge.
    for (int k = 0; k < 3; k++)
      cyc(2'b11, 7'($urandom_range(1, 127)), 7'($urandom_range(1, 127)), 1'b0, 2'b00);
    check("full_cnt",   bus.count, 4);
    check("full_ready", bus.fu_done_ready, 2'b00);
    cyc(2'b11, 7'd77, 7'd78, 1'b0, 2'b00);
    check("full_ignored", bus.count, 4);
    drain(10);

    // Tag 0 is accepted but dropped.
    cyc(2'b11, 7'd0, 7'd33, 1'b0, 2'b11);
    check("zero_cnt", bus.count, 1);
    cyc(2'b00, '0, '0, 1'b0, 2'b11);
    check("zero_tag", bus.reg1_rdy, 33);
    check("zero_ch2", bus.reg2_rdy_valid, 0);
    drain(3);

    // Flush while channel 1 holds tag 20 with two tags queued.
    cyc(2'b01, 7'd20, '0, 1'b0, 2'b00);
    cyc(2'b11, 7'd21, 7'd22, 1'b0, 2'b00);
    check("pre_flush_tag", bus.reg1_rdy, 20);
    check("pre_flush_cnt", bus.count, 2);
    cyc(2'b00, '0, '0, 1'b1, 2'b11);
    check("flush_valids", {bus.reg2_rdy_valid, bus.reg1_rdy_valid}, 2'b00);
    check("flush_cnt",    bus.count, 0);
    check("flush_prf",    bus.prf_set_valid, 2'b00);

    // Asynchronous reset in the middle of a hold.
    cyc(2'b01, 7'd44, '0, 1'b0, 2'b00);
    cyc(2'b00, '0, '0, 1'b0, 2'b00);
    check("pre_areset_vld", bus.reg1_rdy_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("areset_vld", bus.reg1_rdy_valid, 0);
    check("areset_tag", bus.reg1_rdy, 0);
    check("areset_cnt", bus.count, 0);
    check("areset_prf", bus.prf_set_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic with the acknowledge rate varying by phase.
    for (int n = 0; n < 600; n++) begin
      logic [TAG_W-1:0] p0;
      logic [TAG_W-1:0] p1;
      logic [1:0]       ak;
      bias = (n / 100) % 5;
      p0 = ($urandom_range(0, 7) == 0) ? '0 : 7'($urandom_range(1, 127));
      p1 = ($urandom_range(0, 7) == 0) ? '0 : 7'($urandom_range(1, 127));
      ak[0] = ($urandom_range(0, 3) < bias);
      ak[1] = ($urandom_range(0, 3) < bias);
      cyc(2'($urandom_range(0, 3)), p0, p1, ($urandom_range(0, 40) == 0), ak);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wakeup_broadcaster.md
Name: wakeup_broadcaster

Overview:
- Producer end of the reservation-station wakeup protocol (reg1_rdy/reg1_rdy_valid/set_reg1_rdy and reg2_* channels).
- Collects completed destination physical-register tags from the two ALUs and queues them in a small FIFO.
- Drives them onto two independent wakeup channels, holding each tag until the reservation station acknowledges it or a hold timeout expires.
- Sits between the ALU writeback stage and the reservation station; also pulses a PRF scoreboard ready-set strobe per retired broadcast.

Parameters:
- DEPTH, 4, completion FIFO entries (power of 2, ≥2)
- HOLD_MAX, 3, max cycles a tag is held on a channel without ack before forced release (≥1)
- TAG_W, 7, physical register tag width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fu_done_valid  in  2  bit i: ALU i presents a completed destination tag
- fu_prd  in  2×TAG_W  destination tag per ALU; [0] = ALU1, [1] = ALU2
- fu_done_ready  out  2  bit i: tag i accepted this cycle if valid
- flush  in  1  synchronous clear of FIFO and both channels
- reg1_rdy  out  TAG_W  channel-1 tag
- reg1_rdy_valid  out  1  channel-1 valid
- set_reg1_rdy  in  1  channel-1 acknowledge from the reservation station
- reg2_rdy  out  TAG_W  channel-2 tag
- reg2_rdy_valid  out  1  channel-2 valid
- set_reg2_rdy  in  1  channel-2 acknowledge
- prf_set_valid  out  2  bit c: channel c+1 retired a tag this cycle
- prf_set_tag  out  2×TAG_W  tag being retired per channel
- count  out  $clog2(DEPTH)+1  FIFO occupancy (debug)

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, both channels IDLE, reg*_rdy=0, reg*_rdy_valid=0, prf_set_valid=0, prf_set_tag=0, hold counters=0.
- fu_done_ready[0] = (DEPTH-count ≥ 1); fu_done_ready[1] = (DEPTH-count ≥ 2). Both use the registered count only, ignoring same-cycle pops (conservative).
- Push: each accepted tag with prd≠0 is written to the FIFO. ALU1 goes before ALU2 when both push in the same cycle. prd==0 is accepted and dropped (no write, no broadcast).
- Channel FSM, per channel, states IDLE/HOLD:
  - IDLE: if a FIFO entry is available at the edge, load the tag into reg_rdy, assert valid next cycle, set hold_cnt=1, go to HOLD.
  - HOLD: reg_rdy must stay stable while valid=1.
  - HOLD with ack (set_regN_rdy) high at an edge → retire.
  - HOLD with hold_cnt==HOLD_MAX and no ack → retire (no consumer was waiting).
  - HOLD otherwise → hold_cnt++.
  - Retire: prf_set_valid[c]=1 and prf_set_tag[c]=tag for exactly one cycle (registered). Then either reload from the FIFO at that same edge (back-to-back, valid stays 1 with the new tag) or drop valid and return to IDLE.
- Pop priority: channel 1 takes the FIFO head; channel 2 takes the next entry. If only channel 2 is free, it takes the head. At most 2 pops per cycle.
- Acks are only meaningful while valid=1; an ack while IDLE is ignored.
- Occupancy update: count_next = count + pushes − pops, range 0..DEPTH. The FIFO never overflows (guaranteed by ready) or underflows (pop only when count > pops already granted). Read/write pointers wrap modulo DEPTH.
- A push into an empty FIFO cannot be loaded onto a channel in the same cycle; minimum latency from fu_done_valid to regN_rdy_valid is 2 cycles.
- flush (sync, highest priority after reset): count=0, pointers=0, both channels IDLE, valids 0, no prf_set pulse, same-cycle pushes discarded.
- Reset deasserting mid-operation leaves the block in the reset state; in-flight tags are lost by design.

Decomposition:
- Into types_pkg: WAKEUP_TAG_W=7, a wakeup_ch_state_t enum {WK_IDLE, WK_HOLD}, and a wakeup_bcast_t struct {logic valid; logic [6:0] tag}.
- One sub-module: wakeup_tag_fifo. It is a 2-write/2-read circular FIFO exposing count, the two head entries, push[1:0] and pop[1:0]. The broadcaster instantiates it alongside two copies of the channel FSM logic.

Test Plan:
- Single tag: fu_prd[0]=7'd12, valid for 1 cycle; ack held high → reg1_rdy=12 with valid 2 cycles later, released after 1 cycle. prf_set_valid=2'b01, prf_set_tag[0]=12. Channel 2 never valid.
- Dual push, no ack, HOLD_MAX=3: tags 5 and 9 pushed in the same cycle → ch1=5 and ch2=9 both valid for exactly 3 cycles, then both retire together (prf_set_valid=2'b11), then IDLE.
- Back-to-back: 6 tags 1..6 pushed 2 per cycle, ack always high → every tag appears once in order (1,2 / 3,4 / 5,6). fu_done_ready drops when count reaches 3 and 4. No tag is lost or duplicated.
- Full FIFO with DEPTH=4 and no ack: when count=4, fu_done_ready=2'b00 and pushes are ignored; count=3 → 2'b01.
- prd==0 filter: push tags 0 and 33 → only 33 is broadcast, on ch1, and count increments by 1.
- flush while ch1 HOLD(tag 20) with count=2 → next cycle both valids are 0, count=0, and no prf_set pulse. Async reset asserted mid-HOLD → all outputs 0 immediately, without waiting for a clock edge.
